// File: rtl/timer_irq_source_pkg.sv
// Shared bus constants, timer register map and helpers for the timer/compare
// interrupt source.
package timer_irq_source_pkg;

    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;

    typedef enum logic [BUS_ACC_WIDTH-1:0] {
        BUS_ACC_1B = 2'd0,
        BUS_ACC_2B = 2'd1,
        BUS_ACC_4B = 2'd2
    } bus_acc_e;

    localparam int TMR_VA_WIDTH = 4;

    localparam logic [TMR_VA_WIDTH-1:0] TMR_CTRL = 4'h0;
    localparam logic [TMR_VA_WIDTH-1:0] TMR_CMP  = 4'h4;
    localparam logic [TMR_VA_WIDTH-1:0] TMR_CNT  = 4'h8;
    localparam logic [TMR_VA_WIDTH-1:0] TMR_STAT = 4'hC;

    localparam int TMR_EN        = 0;
    localparam int TMR_AR        = 1;
    localparam int TMR_IE        = 2;
    localparam int TMR_PSC_LSB   = 8;
    localparam int TMR_STAT_PEND = 0;

    // Bit of the interrupt controller's ext_int_from vector driven by irq.
    localparam int EXT_INT_SRC_TMR = 3;

    function automatic logic tmr_access_illegal(
        input logic [BUS_ACC_WIDTH-1:0] acc,
        input logic [1:0]               byte_off
    );
        return (acc != BUS_ACC_4B) || (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/timer_irq_source_prescaler.sv
// Clock prescaler: counts 0..psc while enabled and emits a one-cycle tick on
// the wrap back to 0. A restart clears the count and swallows that cycle's tick.
module timer_irq_source_prescaler #(
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PSC_WIDTH-1:0] psc,
    input  logic                 restart,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] psc_cnt_r;
    logic                 wrap_s;

    assign wrap_s = (psc_cnt_r == psc);

    // Tick is qualified by enable and suppressed by a CTRL rewrite.
    always_comb begin
        tick = en & ~restart & wrap_s;
    end

    // Prescale counter, held at 0 while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_r <= '0;
        end else if (!en || restart || wrap_s) begin
            psc_cnt_r <= '0;
        end else begin
            psc_cnt_r <= psc_cnt_r + {{(PSC_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped timer/compare peripheral raising a level interrupt once per
// compare match; bus decode, registers and compare logic live here.
module timer_irq_source
    import timer_irq_source_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int PSC_WIDTH = 8,
    parameter int VA_WIDTH  = TMR_VA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VA_WIDTH-1:0]      addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    input  logic [BUS_WIDTH-1:0]     wdata,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault,
    output logic                     irq
);

    localparam logic [VA_WIDTH-1:0] OFF_CTRL = VA_WIDTH'(TMR_CTRL);
    localparam logic [VA_WIDTH-1:0] OFF_CMP  = VA_WIDTH'(TMR_CMP);
    localparam logic [VA_WIDTH-1:0] OFF_CNT  = VA_WIDTH'(TMR_CNT);
    localparam logic [VA_WIDTH-1:0] OFF_STAT = VA_WIDTH'(TMR_STAT);

    logic                 en_r;
    logic                 ar_r;
    logic                 ie_r;
    logic [PSC_WIDTH-1:0] psc_r;
    logic [CNT_WIDTH-1:0] cmp_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 pend_r;
    logic [BUS_WIDTH-1:0] rdata_r;
    logic                 resp_r;
    logic                 irq_r;

    logic                 illegal_s;
    logic                 legal_s;
    logic                 wr_s;
    logic                 rd_s;
    logic                 wr_ctrl_s;
    logic                 wr_cmp_s;
    logic                 wr_cnt_s;
    logic                 wr_stat_s;
    logic                 tick_s;
    logic                 count_s;
    logic                 match_s;
    logic [BUS_WIDTH-1:0] rd_mux_s;
    logic                 unused_wdata_s;

    assign illegal_s      = tmr_access_illegal(acc, addr[1:0]);
    assign fault          = req & illegal_s;
    assign legal_s        = req & ~illegal_s;
    assign wr_s           = legal_s & w_rb;
    assign rd_s           = legal_s & ~w_rb;
    assign unused_wdata_s = &{1'b0, wdata};

    // Write-strobe decode per register.
    always_comb begin
        wr_ctrl_s = 1'b0;
        wr_cmp_s  = 1'b0;
        wr_cnt_s  = 1'b0;
        wr_stat_s = 1'b0;
        if (wr_s) begin
            case (addr)
                OFF_CTRL: wr_ctrl_s = 1'b1;
                OFF_CMP:  wr_cmp_s  = 1'b1;
                OFF_CNT:  wr_cnt_s  = 1'b1;
                OFF_STAT: wr_stat_s = 1'b1;
                default:  wr_ctrl_s = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    timer_irq_source_prescaler #(
        .PSC_WIDTH (PSC_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en_r),
        .psc     (psc_r),
        .restart (wr_ctrl_s),
        .tick    (tick_s)
    );

    // A software CNT write takes priority over a same-cycle tick.
    assign count_s = tick_s & ~wr_cnt_s;
    assign match_s = count_s & (cnt_r == cmp_r);

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rd_mux_s = '0;
        case (addr)
            OFF_CTRL: begin
                rd_mux_s[TMR_EN]                     = en_r;
                rd_mux_s[TMR_AR]                     = ar_r;
                rd_mux_s[TMR_IE]                     = ie_r;
                rd_mux_s[TMR_PSC_LSB +: PSC_WIDTH]   = psc_r;
            end
            OFF_CMP:  rd_mux_s[CNT_WIDTH-1:0]        = cmp_r;
            OFF_CNT:  rd_mux_s[CNT_WIDTH-1:0]        = cnt_r;
            OFF_STAT: rd_mux_s[TMR_STAT_PEND]        = pend_r;
            default:  rd_mux_s                       = '0;
        endcase
    end

    // CTRL register; a one-shot match drops EN.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r  <= 1'b0;
            ar_r  <= 1'b0;
            ie_r  <= 1'b0;
            psc_r <= '0;
        end else if (wr_ctrl_s) begin
            en_r  <= wdata[TMR_EN];
            ar_r  <= wdata[TMR_AR];
            ie_r  <= wdata[TMR_IE];
            psc_r <= wdata[TMR_PSC_LSB +: PSC_WIDTH];
        end else if (match_s && !ar_r) begin
            en_r  <= 1'b0;
        end
    end

    // Compare and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_r <= '0;
            cnt_r <= '0;
        end else begin
            if (wr_cmp_s) begin
                cmp_r <= wdata[CNT_WIDTH-1:0];
            end
            if (wr_cnt_s) begin
                cnt_r <= wdata[CNT_WIDTH-1:0];
            end else if (match_s) begin
                cnt_r <= ar_r ? '0 : cnt_r;
            end else if (count_s) begin
                cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Pending flag: a hardware set beats a same-cycle W1C so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 1'b0;
        end else if (match_s) begin
            pend_r <= 1'b1;
        end else if (wr_stat_s && wdata[TMR_STAT_PEND]) begin
            pend_r <= 1'b0;
        end
    end

    // Bus response, read data and interrupt level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
            resp_r  <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            resp_r <= legal_s;
            irq_r  <= pend_r & ie_r;
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    assign rdata = rdata_r;
    assign resp  = resp_r;
    assign irq   = irq_r;

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source: a register/fault vector table followed
// by hand-timed auto-reload, one-shot, prescale, collision and reset sequences.
module tb_timer_irq_source;
    import timer_irq_source_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        req;
    logic        resp;
    logic        fault;
    logic        irq;

    int n_tests;
    int n_fail;

    timer_irq_source dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .w_rb  (w_rb),
        .acc   (acc),
        .wdata (wdata),
        .rdata (rdata),
        .req   (req),
        .resp  (resp),
        .fault (fault),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [1:0]  ac;
        logic [31:0] d;
        logic        ef;
        logic        er;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic bus(input logic w, input logic [3:0] a, input logic [1:0] ac,
                       input logic [31:0] d, output logic f, output logic r,
                       output logic [31:0] rd);
        req   = 1'b1;
        w_rb  = w;
        addr  = a;
        acc   = ac;
        wdata = d;
        #1;
        f = fault;
        @(posedge clk);
        #1;
        req   = 1'b0;
        w_rb  = 1'b0;
        wdata = 32'h0;
        r  = resp;
        rd = rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input string nm);
        logic f, r;
        logic [31:0] rd;
        bus(1'b1, a, 2'd2, d, f, r, rd);
        chk({nm, " resp"}, {31'b0, r}, 32'd1);
    endtask

    task automatic rdchk(input logic [3:0] a, input logic [31:0] exp, input string nm);
        logic f, r;
        logic [31:0] rd;
        bus(1'b0, a, 2'd2, 32'h0, f, r, rd);
        chk({nm, " resp"}, {31'b0, r}, 32'd1);
        chk(nm, rd, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic irqchk(input logic exp, input string nm);
        chk(nm, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic f, r;
        logic [31:0] rd;
        n_tests = 0;
        n_fail  = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        req   = 1'b0;
        w_rb  = 1'b0;
        addr  = 4'h0;
        acc   = 2'd2;
        wdata = 32'h0;

        //              w     addr  acc   wdata          fault resp  rdata
        vecs[0]  = '{1'b0, 4'h0, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 4'h4, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 4'h8, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 4'hC, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 4'h4, 2'd2, 32'h12345678,  1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 4'h4, 2'd2, 32'h0,         1'b0, 1'b1, 32'h12345678};
        vecs[6]  = '{1'b1, 4'h4, 2'd1, 32'h0000DEAD,  1'b1, 1'b0, 32'h12345678};
        vecs[7]  = '{1'b0, 4'h4, 2'd2, 32'h0,         1'b0, 1'b1, 32'h12345678};
        vecs[8]  = '{1'b0, 4'h0, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 4'h6, 2'd2, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h2, 2'd2, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 4'h0, 2'd2, 32'hFFFFFEFA,  1'b0, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 4'h0, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0000FE02};
        vecs[13] = '{1'b1, 4'h8, 2'd2, 32'hFFFFFFFF,  1'b0, 1'b1, 32'h0000FE02};
        vecs[14] = '{1'b0, 4'h8, 2'd2, 32'h0,         1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[15] = '{1'b1, 4'hC, 2'd2, 32'hFFFFFFFF,  1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[16] = '{1'b0, 4'hC, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[17] = '{1'b0, 4'h8, 2'd0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 4'h5, 2'd2, 32'hAAAAAAAA,  1'b1, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 4'h4, 2'd2, 32'h0,         1'b0, 1'b1, 32'h12345678};
        vecs[20] = '{1'b1, 4'h0, 2'd2, 32'h0,         1'b0, 1'b1, 32'h12345678};
        vecs[21] = '{1'b0, 4'h0, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0};

        do_reset();
        chk("reset rdata", rdata, 32'h0);
        chk("reset resp", {31'b0, resp}, 32'd0);
        irqchk(1'b0, "reset irq");

        for (int i = 0; i < 22; i++) begin
            bus(vecs[i].w, vecs[i].a, vecs[i].ac, vecs[i].d, f, r, rd);
            chk($sformatf("vec%0d fault", i), {31'b0, f}, {31'b0, vecs[i].ef});
            chk($sformatf("vec%0d resp", i), {31'b0, r}, {31'b0, vecs[i].er});
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].erd);
        end
        irqchk(1'b0, "table irq");

        // Auto-reload CMP=3 PSC=0: matches 4, 8, 12 clocks after the CTRL write.
        do_reset();
        wr(4'h4, 32'd3, "ar cmp wr");
        wr(4'h0, 32'h7, "ar ctrl wr");
        cyc(4);
        irqchk(1'b0, "ar irq before rise");
        cyc(1);
        irqchk(1'b1, "ar irq rise");
        rdchk(4'hC, 32'd1, "ar stat pend");
        wr(4'hC, 32'd1, "ar w1c1");
        cyc(1);
        irqchk(1'b0, "ar irq cleared1");
        cyc(1);
        irqchk(1'b1, "ar irq rerise1");
        wr(4'hC, 32'd1, "ar w1c2");
        cyc(1);
        irqchk(1'b0, "ar irq cleared2a");
        cyc(1);
        irqchk(1'b0, "ar irq cleared2b");
        cyc(1);
        irqchk(1'b1, "ar irq rerise2");

        // Reset while counting with PEND set.
        do_reset();
        irqchk(1'b0, "midrst irq");
        chk("midrst resp", {31'b0, resp}, 32'd0);
        chk("midrst rdata", rdata, 32'h0);
        rdchk(4'h0, 32'h0, "midrst ctrl");
        rdchk(4'h4, 32'h0, "midrst cmp");
        rdchk(4'h8, 32'h0, "midrst cnt");
        rdchk(4'hC, 32'h0, "midrst stat");
        cyc(6);
        irqchk(1'b0, "midrst irq later");

        // One-shot CMP=2: match on the 3rd tick, EN drops, CNT holds.
        do_reset();
        wr(4'h4, 32'd2, "os cmp wr");
        wr(4'h0, 32'h5, "os ctrl wr");
        cyc(3);
        irqchk(1'b0, "os irq before rise");
        cyc(1);
        irqchk(1'b1, "os irq rise");
        rdchk(4'h0, 32'h4, "os ctrl en clear");
        rdchk(4'h8, 32'd2, "os cnt held");
        cyc(3);
        irqchk(1'b1, "os irq held");
        rdchk(4'h8, 32'd2, "os cnt still held");
        wr(4'hC, 32'd1, "os w1c");
        irqchk(1'b1, "os irq at clear");
        cyc(1);
        irqchk(1'b0, "os irq after clear");
        rdchk(4'hC, 32'd0, "os stat cleared");

        // Prescale PSC=2 CMP=1: ticks every 3 clocks, PEND set 6 clocks in.
        do_reset();
        wr(4'h4, 32'd1, "psc cmp wr");
        wr(4'h0, 32'h201, "psc ctrl wr");
        cyc(2);
        rdchk(4'h8, 32'd0, "psc cnt before tick");
        rdchk(4'h8, 32'd1, "psc cnt after tick");
        cyc(1);
        rdchk(4'hC, 32'd0, "psc pend before match");
        rdchk(4'hC, 32'd1, "psc pend after match");

        // W1C in the exact match cycle: the match wins.
        do_reset();
        wr(4'h4, 32'd3, "col cmp wr");
        wr(4'h0, 32'h7, "col ctrl wr");
        cyc(7);
        wr(4'hC, 32'd1, "col w1c");
        irqchk(1'b1, "col irq at collision");
        cyc(1);
        irqchk(1'b1, "col irq after collision");
        rdchk(4'hC, 32'd1, "col pend kept");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_irq_source.md
Name: timer_irq_source

Overview:
- Memory-mapped 32-bit timer/compare peripheral that generates interrupt requests for the external interrupt controller.
- Its `irq` output is one bit of the controller's `ext_int_from` vector. The controller edge-detects that bit, so `irq` is a level that rises once per compare event.
- Sits on the peripheral bus with the standard req/resp/fault slave protocol.

Parameters:
- CNT_WIDTH, 32: counter and compare width; must be at most BUS_WIDTH.
- PSC_WIDTH, 8: prescaler field width.
- VA_WIDTH, 4: local address width (four word registers).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr  in  VA_WIDTH  register byte offset.
- w_rb  in  1  1 = write, 0 = read.
- acc  in  BUS_ACC_WIDTH  access size; only BUS_ACC_4B is legal.
- wdata  in  BUS_WIDTH  write data.
- rdata  out  BUS_WIDTH  read data; registered, valid when resp=1.
- req  in  1  access request, single cycle.
- resp  out  1  completion pulse, one cycle after a legal req.
- fault  out  1  combinational; equals req & illegal access.
- irq  out  1  interrupt level to the controller; registered.

Behaviour:
- Reset (rst=1 at a clock edge):
  - CTRL, CMP, CNT, PEND, prescaler count are 0.
  - rdata=0, resp=0, irq=0.
  - Reset asserted mid-count aborts the count with no residual pending.
- Register map (word offsets):
  - 0x0 CTRL: [0] EN, [1] AR (auto-reload), [2] IE, [8+:PSC_WIDTH] PSC.
  - 0x4 CMP.
  - 0x8 CNT.
  - 0xC STAT: [0] PEND, write-1-to-clear.
  - Unused bits read 0; writes to them are ignored.
- Illegal access:
  - An access is illegal if acc != BUS_ACC_4B or addr[1:0] != 0.
  - For an illegal access: fault=1 in the same cycle, resp stays 0, no register changes, rdata holds its value.
- Legal access:
  - resp=1 exactly one cycle after req.
  - Reads load rdata in the same edge that sets resp.
  - Writes take effect at that same edge.
- Prescaler:
  - While EN=1, the prescaler counts 0..PSC and asserts a one-cycle tick when it wraps to 0.
  - Ticks therefore occur every PSC+1 clocks; PSC=0 gives a tick every clock.
  - While EN=0 the prescaler is held at 0.
  - Any write to CTRL resets the prescaler to 0.
- Counter, on each tick:
  - If CNT==CMP, a match occurs:
    - PEND<=1.
    - If AR=1: CNT<=0.
    - If AR=0: CNT holds and EN<=0 (one-shot).
  - Otherwise CNT<=CNT+1, wrapping modulo 2^CNT_WIDTH.
  - Period is (CMP+1)*(PSC+1) clocks. CMP=0 with AR=1 matches on every tick.
- Simultaneous events:
  - A software write to CNT in the same cycle as a tick wins over the tick.
  - A CTRL write clearing EN in a tick cycle suppresses that tick.
  - A hardware PEND set wins over a W1C clear in the same cycle, so no event is lost.
- irq:
  - irq <= PEND & IE, registered: rises one cycle after PEND sets.
  - irq stays high until software clears PEND or IE. This gives the controller one rising edge per event, provided software clears PEND before the next match.
  - With AR=1 and PEND never cleared, irq stays high and the controller sees no further edges; this is accepted behaviour.
- Reads of CNT return the current register value; there is no snapshot.

Decomposition:
- femto.vh additions:
  - TMR_VA_WIDTH.
  - Register offsets TMR_CTRL, TMR_CMP, TMR_CNT, TMR_STAT.
  - CTRL bit positions TMR_EN, TMR_AR, TMR_IE, TMR_PSC_LSB.
  - EXT_INT_SRC index assigned to this timer.
- One natural sub-module: timer_prescaler (en, psc, restart -> tick), roughly 30 lines.
- Bus decode, registers and compare logic stay in the top module.

Test Plan:
- Reset: pulse rst mid-count → next-cycle reads of all four registers return 0; irq=0; resp=0.
- Auto-reload: CMP=3, write CTRL=EN|AR|IE, PSC=0 → PEND sets on the 4th tick after the CTRL write, irq rises one cycle later; W1C STAT each time → PEND re-sets every 4 clocks.
- One-shot: CMP=2, CTRL=EN|IE (AR=0) → after the match, CTRL reads EN=0, CNT reads 2, irq stays high until STAT W1C, then goes low one cycle after the clear.
- Prescale: PSC=2, CMP=1, EN|AR → ticks every 3 clocks, PEND sets 6 clocks after the CTRL write.
- Collision: W1C STAT issued in the exact match cycle → PEND reads 1 afterwards and irq stays high.
- Faults:
  - acc=2B write to 0x4 → fault=1 the same cycle, no resp, CMP unchanged.
  - 4B read at addr 0x2 → fault=1, rdata unchanged.
